// File: rtl/regs_sb.sv
// regs_sb: integer register file with a per-register pending-write scoreboard.
// NRD combinational read ports with optional write-back bypass, one write-back and one claim per cycle.
module regs_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_mem_dat,
  input  logic            i_busy,
  input  logic            i_wb_val,
  input  logic [AW-1:0]   i_wb_rd,
  input  logic [XLEN-1:0] i_wb_dat,
  output logic [XLEN-1:0] o_dat,
  output logic            o_ok
);
  logic w_hit;
  assign w_hit = (BYPASS != 0) && i_wb_val && (i_wb_rd == i_addr);

  always_comb begin
    o_dat = i_mem_dat;
    o_ok  = ~i_busy;
    if (i_addr == '0) begin
      o_dat = '0;
      o_ok  = 1'b1;
    end else if (w_hit) begin
      o_dat = i_wb_dat;
      o_ok  = 1'b1;
    end
  end
endmodule

module regs_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_dat,
  output logic [NRD-1:0]      rd_ok,
  input  logic                issue_val,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_rdy,
  input  logic                wb_val,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_dat,
  input  logic                flush,
  output logic [NREG-1:0]     busy,
  output logic [AW:0]         pend_cnt
);
  logic [NREG-1:0][XLEN-1:0] r_mem;
  logic [NREG-1:0]           r_busy;
  logic [AW:0]               r_pend_cnt;

  logic                      w_wr, w_claim;
  logic [NREG-1:0]           w_busy_nxt;
  logic [AW:0]               w_cnt_nxt;
  logic [NRD-1:0][AW-1:0]    w_ra;
  logic [NRD-1:0][XLEN-1:0]  w_rdat;

  assign w_wr      = wb_val && (wb_rd != '0);
  assign issue_rdy = ~r_busy[issue_rd] | (wb_val && (wb_rd == issue_rd)) | (issue_rd == '0);
  assign w_claim   = issue_val && issue_rdy && (issue_rd != '0);

  // Claim is applied after the write-back clear so it wins; flush overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr)    w_busy_nxt[wb_rd]    = 1'b0;
    if (w_claim) w_busy_nxt[issue_rd] = 1'b1;
    if (flush)   w_busy_nxt           = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem      <= '0;
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr) r_mem[wb_rd] <= wb_dat;
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign pend_cnt = r_pend_cnt;
  assign w_ra     = rd_addr;
  assign rd_dat   = w_rdat;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regs_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .i_addr    (w_ra[p]),
      .i_mem_dat (r_mem[w_ra[p]]),
      .i_busy    (r_busy[w_ra[p]]),
      .i_wb_val  (wb_val),
      .i_wb_rd   (wb_rd),
      .i_wb_dat  (wb_dat),
      .o_dat     (w_rdat[p]),
      .o_ok      (rd_ok[p])
    );
  end
endmodule
